// File: rtl/rom_fetch_bridge_pkg.sv
// ----------------------------------------------------------------------------
// rom_fetch_bridge_pkg
// Shared definitions for the instruction-fetch ROM bridge: default bus widths,
// the fetch FSM state encoding (kept stable so a data-side bridge can reuse it)
// and a small word-alignment helper.
// ----------------------------------------------------------------------------
package rom_fetch_bridge_pkg;

    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/rom_fetch_bridge_fetch_buf.sv
// ----------------------------------------------------------------------------
// rom_fetch_bridge_fetch_buf
// Single-entry fetch buffer holding the last word returned by memory, plus the
// hit comparator used to serve an unchanged PC without a memory transaction.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_fill_en        write i_fill_addr/i_fill_data into the buffer, mark valid
//   i_fill_addr      address of the word being filled
//   i_fill_data      word being filled
//   i_lookup_en      lookup qualifier (fetch enable)
//   i_lookup_addr    address being looked up
//   o_hit            lookup_en && buffer valid && address match
//   o_data           buffered word (meaningful only with o_hit)
// ----------------------------------------------------------------------------
module rom_fetch_bridge_fetch_buf
    import rom_fetch_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_BUS,
    parameter int unsigned DATA_W = DATA_BUS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fill_en,
    input  logic [ADDR_W-1:0] i_fill_addr,
    input  logic [DATA_W-1:0] i_fill_data,
    input  logic              i_lookup_en,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [DATA_W-1:0] r_buf_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else if (i_fill_en) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= i_fill_addr;
            r_buf_data  <= i_fill_data;
        end
    end

    assign o_hit  = i_lookup_en && r_buf_valid && (i_lookup_addr == r_buf_addr);
    assign o_data = r_buf_data;

endmodule

// File: rtl/rom_fetch_bridge.sv
// ----------------------------------------------------------------------------
// rom_fetch_bridge
// Responder for the IF-stage ROM port. A fetch that hits the one-word fetch
// buffer is served combinationally; a miss is turned into one request/response
// transaction on an SRAM-like bus (separate address and data handshakes) while
// o_stall_req holds the pipeline.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_rom_en           fetch enable from the PC
//   i_rom_write_en     byte write enables (must be zero; nonzero flags o_write_err)
//   i_rom_addr         fetch address
//   i_rom_write_data   ignored, the ROM is never written
//   o_rom_read_data    buffered word on a hit, otherwise zero
//   o_stall_req        fetch not yet satisfied
//   o_addr_err         sticky: fetch with a misaligned address
//   o_write_err        sticky: fetch with nonzero write enables
//   o_mem_req          memory request valid (held until i_mem_addr_ok)
//   o_mem_addr         memory word address
//   i_mem_addr_ok      memory accepted the request this cycle
//   i_mem_data_ok      i_mem_rdata valid this cycle
//   i_mem_rdata        memory read data
// ----------------------------------------------------------------------------
module rom_fetch_bridge
    import rom_fetch_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_BUS,
    parameter int unsigned DATA_W = DATA_BUS,
    parameter int unsigned SEL_W  = MEM_SEL_BUS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rom_en,
    input  logic [SEL_W-1:0]  i_rom_write_en,
    input  logic [ADDR_W-1:0] i_rom_addr,
    input  logic [DATA_W-1:0] i_rom_write_data,
    output logic [DATA_W-1:0] o_rom_read_data,
    output logic              o_stall_req,
    output logic              o_addr_err,
    output logic              o_write_err,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_addr_ok,
    input  logic              i_mem_data_ok,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_addr_err;
    logic              r_write_err;

    logic              w_aligned;
    logic              w_hit;
    logic              w_miss;
    logic              w_fill_en;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_unused_write_data;

    assign w_aligned = is_word_aligned(i_rom_addr[1:0]);
    // Misaligned fetches never miss: no request and no stall, only the error flag.
    assign w_miss    = i_rom_en && w_aligned && !w_hit;
    // Data handshakes outside WAIT (stale or early responses) are dropped.
    assign w_fill_en = (r_state == StWait) && i_mem_data_ok;

    assign w_unused_write_data = ^i_rom_write_data;

    rom_fetch_bridge_fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_buf (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_fill_en     (w_fill_en),
        .i_fill_addr   (r_req_addr),
        .i_fill_data   (i_mem_rdata),
        .i_lookup_en   (i_rom_en),
        .i_lookup_addr (i_rom_addr),
        .o_hit         (w_hit),
        .o_data        (w_buf_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_req_addr  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_addr_err  <= 1'b0;
            r_write_err <= 1'b0;
        end else begin
            if (i_rom_en && !w_aligned) begin
                r_addr_err <= 1'b1;
            end
            if (i_rom_en && (|i_rom_write_en)) begin
                r_write_err <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_miss) begin
                        r_req_addr <= i_rom_addr;
                        r_mem_addr <= i_rom_addr;
                        r_mem_req  <= 1'b1;
                        r_state    <= StReq;
                    end
                end
                StReq: begin
                    if (i_mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= StWait;
                    end
                end
                StWait: begin
                    // Completes even if the PC moved away; the fill uses r_req_addr.
                    if (i_mem_data_ok) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign o_stall_req     = w_miss;
    assign o_rom_read_data = w_hit ? w_buf_data : '0;
    assign o_addr_err      = r_addr_err;
    assign o_write_err     = r_write_err;
    assign o_mem_req       = r_mem_req;
    assign o_mem_addr      = r_mem_addr;

endmodule

// File: doc/rom_fetch_bridge.md
# rom_fetch_bridge

Responder for the instruction-fetch ROM port driven by the IF-stage program counter. Accepts `rom_en`/`rom_addr` and returns `rom_read_data`. Converts each new fetch into a request/response transaction on an SRAM-like memory bus with separate address and data handshakes. Holds the last fetched word so a stalled, unchanged PC is served with zero stall, and raises `stall_req` to the pipeline stall controller while a fetch is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, fetch/memory address width
- `DATA_W`, 32, instruction word width
- `SEL_W`, 4, byte-select width of `rom_write_en`

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rom_en`  in  1  fetch enable from PC
- `rom_write_en`  in  SEL_W  write byte enables from PC; must be 0
- `rom_addr`  in  ADDR_W  fetch address
- `rom_write_data`  in  DATA_W  ignored
- `rom_read_data`  out  DATA_W  instruction word for `rom_addr`
- `stall_req`  out  1  fetch not yet satisfied; stall controller turns it into `stall_pc`
- `addr_err`  out  1  sticky: fetch with `rom_addr[1:0]!=0`
- `write_err`  out  1  sticky: `rom_en` with nonzero `rom_write_en`
- `mem_req`  out  1  memory request valid
- `mem_addr`  out  ADDR_W  memory word address
- `mem_addr_ok`  in  1  memory accepted request this cycle
- `mem_data_ok`  in  1  `mem_rdata` valid this cycle
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- Fetch buffer: `buf_valid`, `buf_addr`, `buf_data`.
- Hit: `rom_en && buf_valid && rom_addr==buf_addr`.
- FSM states:
  - IDLE: on `rom_en && !hit && aligned`, latch `rom_addr` into `req_addr` and go to REQ.
  - REQ: drive `mem_req=1`, `mem_addr=req_addr`. On `mem_addr_ok`, go to WAIT.
  - WAIT: on `mem_data_ok`, write `buf_data<=mem_rdata`, `buf_addr<=req_addr`, `buf_valid<=1`, then go to IDLE.
- `stall_req` (combinational) = `rom_en && aligned && !hit`. It is asserted from the first cycle of a miss, including while in IDLE.
- `rom_read_data` = `buf_data` on hit; otherwise 0.
- Misaligned fetch:
  - no request issued;
  - `stall_req=0`, `rom_read_data=0`;
  - `addr_err` set.
- `write_err` is set whenever `rom_en` is high with nonzero `rom_write_en`. The memory is never written; the fetch proceeds normally.
- `rom_en` low: `stall_req=0` and no new request. An in-flight transaction always completes and fills the buffer; it is never aborted.
- `rom_addr` changes mid-fetch: the transaction completes with `req_addr`, and the new address is then a miss.
- `mem_data_ok` outside WAIT is ignored, including stale responses after reset.
- `mem_addr_ok` and `mem_data_ok` only have effect in their own state. A simultaneous `mem_data_ok` while in REQ is ignored, so memory must answer at least one cycle after accepting.

## Timing
- Reset (async, `rst=0`) forces:
  - state=IDLE;
  - `buf_valid=0`, `buf_addr=0`, `buf_data=0`;
  - `mem_req=0`, `mem_addr=0`;
  - `addr_err=0`, `write_err=0`;
  - `rom_read_data=0`.
- `stall_req` follows combinationally from the inputs (value per Operation).
- Miss with `mem_addr_ok` in the first REQ cycle and `mem_data_ok` in the next cycle:
  - C0: IDLE, `stall_req=1`;
  - C1: REQ, `mem_req=1`;
  - C2: WAIT;
  - C3: hit, `stall_req=0`, data valid.
- Minimum miss penalty is 3 stall cycles; hit penalty is 0.
- `mem_req` stays high, with `mem_addr` stable, until `mem_addr_ok`. Only one outstanding transaction at a time.
- Back-to-back sequential fetches each cost one full miss; there is no prefetch.

## Structure
- Width macros `ADDR_BUS`, `DATA_BUS`, `MEM_SEL_BUS` come from the shared bus header.
- FSM state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2) go in a new shared header, `romdef.v`, reused by a future data-side bridge.
- One sub-module, `fetch_buf`, holds `buf_valid`/`buf_addr`/`buf_data`, the fill port and the hit comparator.

## Test plan
- Cold fetch of 0xBFC00000, memory returns 0x3C1D8000 with `mem_addr_ok` in C1 and `mem_data_ok` in C2 → `stall_req` high for C0–C2; C3 shows `rom_read_data=0x3C1D8000`; exactly one `mem_req` handshake.
- PC held at 0xBFC00000 for 10 cycles after fill → `stall_req=0` all cycles, `mem_req` never rises, data stable.
- Memory holds off `mem_addr_ok` for 4 cycles, then `mem_data_ok` after 3 more → `mem_req`/`mem_addr` stable through the wait; `stall_req` for 9 cycles total; correct word delivered.
- `rom_addr=0xBFC00002` → `addr_err=1` next cycle and stays set, `stall_req=0`, no request. `rom_write_en=4'hF` with valid address → `write_err=1` and fetch completes normally.
- Assert `rst=0` while in WAIT, release, then drive a stale `mem_data_ok` with data 0xDEADBEEF → FSM in IDLE, `buf_valid=0`, 0xDEADBEEF never appears on `rom_read_data`; the next fetch misses and fills correctly.
